// File: rtl/debug_slave_pkg.sv
// Shared types and constants for the debug slave sysclk command path.
package debug_slave_pkg;

    localparam int DBG_IR_W    = 2;
    localparam int DBG_DR_W    = 38;
    localparam int DBG_NUM_IR  = 2 ** DBG_IR_W;
    localparam int DBG_ACT_BIT = 34;

    typedef struct packed {
        logic [DBG_IR_W-1:0] ir;
        logic [DBG_DR_W-1:0] data;
    } dbg_cmd_t;

    function automatic logic [DBG_NUM_IR-1:0] ir_onehot(input logic [DBG_IR_W-1:0] ir);
        ir_onehot     = '0;
        ir_onehot[ir] = 1'b1;
    endfunction

endpackage

// File: rtl/debug_slave_sysclk_cmdq_if.sv
// Command delivery bundle between the debug slave and the CPU debug logic.
interface debug_slave_sysclk_cmdq_if
    import debug_slave_pkg::*;
#(
    parameter int IR_W = DBG_IR_W,
    parameter int DR_W = DBG_DR_W
);
    localparam int NUM_IR = 2 ** IR_W;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [IR_W-1:0]   cmd_ir;
    logic [DR_W-1:0]   jdo;
    logic [NUM_IR-1:0] take_action;
    logic [NUM_IR-1:0] take_no_action;

    modport master (
        output cmd_valid, cmd_ir, jdo, take_action, take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ir, jdo, take_action, take_no_action,
        output cmd_ready
    );
endinterface

// File: rtl/debug_slave_bit_sync.sv
// Multi-stage level synchroniser; primed goes high once the chain holds real samples.
module debug_slave_bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic primed
);
    logic [SYNC_STAGES-1:0] chain;
    logic [SYNC_STAGES-1:0] fill;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            fill  <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign q      = chain[SYNC_STAGES-1];
    assign primed = fill[SYNC_STAGES-1];
endmodule

// File: rtl/debug_slave_sysclk_cmdq.sv
// Sysclk side of the JTAG debug slave: strobe sync, command capture, queued delivery.
// Define DEBUG_SLAVE_CMDQ_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise one holding register.
module debug_slave_sysclk_cmdq
    import debug_slave_pkg::*;
#(
    parameter int  IR_W        = DBG_IR_W,
    parameter int  DR_W        = DBG_DR_W,
    parameter int  ACT_BIT     = DBG_ACT_BIT,
    parameter int  SYNC_STAGES = 2,
    parameter int  FIFO_DEPTH  = 4,
    localparam int NUM_IR      = 2 ** IR_W,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vs_udr,
    input  logic                      vs_uir,
    input  logic [IR_W-1:0]           ir_in,
    input  logic [DR_W-1:0]           sr,
    debug_slave_sysclk_cmdq_if.master cmd,
    output logic                      ir_update,
    output logic                      overflow,
    output logic [LVL_W-1:0]          level
);
    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] data;
    } cmd_t;

    logic udr_s, udr_primed, udr_prev, udr_armed, udr_edge;
    logic uir_s, uir_primed, uir_prev, uir_armed, uir_edge;
    logic push_q;
    cmd_t cap_q;
    logic pop;
    logic drop;

    debug_slave_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk    (clk),
        .reset  (reset),
        .d      (vs_udr),
        .q      (udr_s),
        .primed (udr_primed)
    );

    debug_slave_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk    (clk),
        .reset  (reset),
        .d      (vs_uir),
        .q      (uir_s),
        .primed (uir_primed)
    );

    // A strobe already high at reset release never arms: only a genuine sampled 0 does.
    assign udr_edge = udr_armed & udr_s & ~udr_prev;
    assign uir_edge = uir_armed & uir_s & ~uir_prev;
    assign pop      = cmd.cmd_valid & cmd.cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            udr_prev  <= 1'b0;
            udr_armed <= 1'b0;
            uir_prev  <= 1'b0;
            uir_armed <= 1'b0;
            push_q    <= 1'b0;
            cap_q     <= '0;
        end else begin
            udr_prev  <= udr_s;
            udr_armed <= udr_armed | (udr_primed & ~udr_s);
            uir_prev  <= uir_s;
            uir_armed <= uir_armed | (uir_primed & ~uir_s);
            push_q    <= udr_edge;
            if (udr_edge) begin
                cap_q.ir   <= ir_in;
                cap_q.data <= sr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_update          <= 1'b0;
            overflow           <= 1'b0;
            cmd.take_action    <= '0;
            cmd.take_no_action <= '0;
        end else begin
            ir_update          <= uir_edge;
            cmd.take_action    <= '0;
            cmd.take_no_action <= '0;
            if (drop)
                overflow <= 1'b1;
            else if (uir_edge)
                overflow <= 1'b0;
            if (pop) begin
                if (cmd.jdo[ACT_BIT])
                    cmd.take_action    <= NUM_IR'(1) << cmd.cmd_ir;
                else
                    cmd.take_no_action <= NUM_IR'(1) << cmd.cmd_ir;
            end
        end
    end

`ifdef DEBUG_SLAVE_CMDQ_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    cmd_t          mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic          full, wr_en;
    cmd_t          head_nxt;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign wr_en = push_q & (~full | pop);
    assign drop  = push_q & full & ~pop;

    // Output registers are loaded with the post-edge head, bypassing the write when it lands there.
    always_comb begin
        wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, wr_en};
        rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
        head_nxt   = mem[rd_ptr_nxt[AW-1:0]];
        if (wr_en && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]))
            head_nxt = cap_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_ir    <= '0;
            cmd.jdo       <= '0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            cmd.cmd_valid <= (wr_ptr_nxt != rd_ptr_nxt);
            if (wr_ptr_nxt != rd_ptr_nxt) begin
                cmd.cmd_ir <= head_nxt.ir;
                cmd.jdo    <= head_nxt.data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= cap_q;
    end
`else
    logic load;

    assign load  = push_q & (~cmd.cmd_valid | pop);
    assign drop  = push_q & cmd.cmd_valid & ~pop;
    assign level = LVL_W'(cmd.cmd_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_ir    <= '0;
            cmd.jdo       <= '0;
        end else if (load) begin
            cmd.cmd_valid <= 1'b1;
            cmd.cmd_ir    <= cap_q.ir;
            cmd.jdo       <= cap_q.data;
        end else if (pop) begin
            cmd.cmd_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_debug_slave_sysclk_cmdq.sv
// Self-checking bench for debug_slave_sysclk_cmdq (queue or single-register build).
module tb_debug_slave_sysclk_cmdq;

`ifdef DEBUG_SLAVE_CMDQ_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int ACT = 34;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] data;
        logic [3:0]  act;
        logic [3:0]  noact;
    } exp_t;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] sr;
        logic [3:0]  act;
        logic [3:0]  noact;
    } vec_t;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        vs_udr = 1'b1;
    logic        vs_uir = 1'b0;
    logic [1:0]  ir_in  = '0;
    logic [37:0] sr     = '0;
    logic        ir_update;
    logic        overflow;
    logic [2:0]  level;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    exp_t        drv_e;
    vec_t        vt[6];
    logic [3:0]  pend_act   = '0;
    logic [3:0]  pend_noact = '0;
    logic [37:0] first_d;
    logic [37:0] d;
    int          nq;

    debug_slave_sysclk_cmdq_if #(.IR_W(2), .DR_W(38)) cmd_if ();

    debug_slave_sysclk_cmdq #(
        .IR_W        (2),
        .DR_W        (38),
        .ACT_BIT     (ACT),
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vs_udr    (vs_udr),
        .vs_uir    (vs_uir),
        .ir_in     (ir_in),
        .sr        (sr),
        .cmd       (cmd_if),
        .ir_update (ir_update),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic exp_t mk(input logic [1:0] ir, input logic [37:0] data);
        exp_t e;
        e.ir    = ir;
        e.data  = data;
        e.act   = data[ACT] ? (4'b0001 << ir) : 4'b0000;
        e.noact = data[ACT] ? 4'b0000 : (4'b0001 << ir);
        return e;
    endfunction

    task automatic strobe(input logic [1:0] ir, input logic [37:0] data);
        ir_in  = ir;
        sr     = data;
        vs_udr = 1'b1;
        step(3);
        vs_udr = 1'b0;
        step(3);
    endtask

    task automatic wait_empty(input string name);
        int k;
        k = 0;
        while (level != 3'd0 && k < 64) begin
            step(1);
            k++;
        end
        chk(name, 64'(level), 64'd0);
    endtask

    // Scoreboard consumer: pops on each handshake, checks head and the following pulse cycle.
    always begin
        @(negedge clk);
        #3;
        if (reset) begin
            pend_act   = '0;
            pend_noact = '0;
        end else begin
            chk("take_action", 64'(cmd_if.take_action), 64'(pend_act));
            chk("take_no_action", 64'(cmd_if.take_no_action), 64'(pend_noact));
            pend_act   = '0;
            pend_noact = '0;
            if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got ir=%0d jdo=%0h, expected no command",
                             cmd_if.cmd_ir, cmd_if.jdo);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pop_ir", 64'(cmd_if.cmd_ir), 64'(mon_e.ir));
                    chk("pop_jdo", 64'(cmd_if.jdo), 64'(mon_e.data));
                    pend_act   = mon_e.act;
                    pend_noact = mon_e.noact;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{2'd3, 38'h2A_5A5A_5A5A, 4'b0000, 4'b1000};
        vt[1] = '{2'd0, 38'h04_0000_0001, 4'b0001, 4'b0000};
        vt[2] = '{2'd2, 38'h3F_FFFF_FFFF, 4'b0100, 4'b0000};
        vt[3] = '{2'd1, 38'h00_0000_0000, 4'b0000, 4'b0010};
        vt[4] = '{2'd0, 38'h3B_1234_5678, 4'b0000, 4'b0001};
        vt[5] = '{2'd3, 38'h15_DEAD_BEEF, 4'b1000, 4'b0000};

        cmd_if.cmd_ready = 1'b0;
        step(3);
        chk("rst_valid", 64'(cmd_if.cmd_valid), 64'd0);
        chk("rst_ir", 64'(cmd_if.cmd_ir), 64'd0);
        chk("rst_jdo", 64'(cmd_if.jdo), 64'd0);
        chk("rst_act", 64'(cmd_if.take_action), 64'd0);
        chk("rst_noact", 64'(cmd_if.take_no_action), 64'd0);
        chk("rst_ir_update", 64'(ir_update), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        reset = 1'b0;

        // vs_udr held high through reset release must not produce a command
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("held_udr_no_valid", 64'(cmd_if.cmd_valid), 64'd0);
        end

        vs_udr = 1'b0;
        step(4);
        ir_in = 2'd1;
        sr    = 38'h04_0000_0123;
        sb.push_back(mk(2'd1, 38'h04_0000_0123));
        vs_udr = 1'b1;
        step(3);
        chk("latency_not_yet", 64'(cmd_if.cmd_valid), 64'd0);
        step(1);
        chk("latency_valid", 64'(cmd_if.cmd_valid), 64'd1);
        chk("latency_ir", 64'(cmd_if.cmd_ir), 64'd1);
        vs_udr = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        step(1);
        cmd_if.cmd_ready = 1'b0;
        chk("first_action", 64'(cmd_if.take_action), 64'h2);
        step(3);

        // table-driven commands with the consumer always ready
        cmd_if.cmd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drv_e.ir    = vt[i].ir;
            drv_e.data  = vt[i].sr;
            drv_e.act   = vt[i].act;
            drv_e.noact = vt[i].noact;
            sb.push_back(drv_e);
            strobe(vt[i].ir, vt[i].sr);
        end
        wait_empty("table_drain");
        step(2);
        cmd_if.cmd_ready = 1'b0;

        // overfill: DEPTH+1 strobes, last one dropped
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = (i % 2 == 0) ? (38'h04_0000_1000 | 38'(i)) : (38'h2B_0000_2000 | 38'(i));
            if (i == 0) first_d = d;
            if (i < DEPTH) sb.push_back(mk(2'(i), d));
            strobe(2'(i), d);
        end
        step(2);
        chk("full_level", 64'(level), 64'(DEPTH));
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_valid", 64'(cmd_if.cmd_valid), 64'd1);
        chk("full_head_jdo", 64'(cmd_if.jdo), 64'(first_d));

        // update-IR strobe clears the sticky overflow
        vs_uir = 1'b1;
        step(2);
        chk("uir_not_yet", 64'(ir_update), 64'd0);
        chk("uir_overflow_held", 64'(overflow), 64'd1);
        step(1);
        chk("uir_pulse", 64'(ir_update), 64'd1);
        step(1);
        chk("uir_pulse_end", 64'(ir_update), 64'd0);
        chk("uir_overflow_clr", 64'(overflow), 64'd0);
        vs_uir = 1'b0;

        cmd_if.cmd_ready = 1'b1;
        wait_empty("overfill_drain");
        step(3);
        cmd_if.cmd_ready = 1'b0;
        chk("overfill_sb_empty", 64'(sb.size()), 64'd0);

        // full queue, new command lands in the same cycle as a pop
        for (int i = 0; i < DEPTH; i++) begin
            d = 38'h11_0000_3000 | 38'(i);
            sb.push_back(mk(2'(i + 1), d));
            strobe(2'(i + 1), d);
        end
        chk("refill_level", 64'(level), 64'(DEPTH));
        ir_in  = 2'd2;
        sr     = 38'h3F_0F0F_0F0F;
        vs_udr = 1'b1;
        step(3);
        sb.push_back(mk(2'd2, 38'h3F_0F0F_0F0F));
        cmd_if.cmd_ready = 1'b1;
        step(1);
        cmd_if.cmd_ready = 1'b0;
        vs_udr = 1'b0;
        chk("pushpop_level", 64'(level), 64'(DEPTH));
        chk("pushpop_overflow", 64'(overflow), 64'd0);
        step(2);
        cmd_if.cmd_ready = 1'b1;
        wait_empty("pushpop_drain");
        step(3);
        cmd_if.cmd_ready = 1'b0;
        chk("pushpop_sb_empty", 64'(sb.size()), 64'd0);

        // reset with commands queued flushes everything
        nq = (DEPTH >= 3) ? 3 : DEPTH;
        for (int i = 0; i < 3; i++) strobe(2'(i), 38'h05_0000_4000 | 38'(i));
        chk("preflush_level", 64'(level), 64'(nq));
        reset = 1'b1;
        step(1);
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_valid", 64'(cmd_if.cmd_valid), 64'd0);
        chk("flush_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        step(4);

        cmd_if.cmd_ready = 1'b1;
        sb.push_back(mk(2'd3, 38'h0A_CAFE_F00D));
        strobe(2'd3, 38'h0A_CAFE_F00D);
        wait_empty("post_reset_drain");
        step(3);
        cmd_if.cmd_ready = 1'b0;
        chk("post_reset_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_slave_sysclk_cmdq.md
# debug_slave_sysclk_cmdq

System-clock side of the JTAG debug slave, generalised for configurable IR/DR widths and buffered command delivery. It brings the virtual-JTAG update strobes (`vs_udr`, `vs_uir`) into the `clk` domain and captures the quasi-static `ir_in`/`sr` values on each update-DR. It queues each captured command, then hands commands one at a time to the CPU debug logic with a valid/ready handshake and per-instruction action pulses. It replaces the fixed 2-bit-IR/38-bit-DR unbuffered sysclk decoder and sits between the debug-slave TCK block and the OCI/break/trace control logic.

## Interface
Parameters:
- `IR_W`, default 2: instruction register width. `NUM_IR = 2**IR_W` action channels.
- `DR_W`, default 38: data register width (`sr`, `jdo`).
- `ACT_BIT`, default 34: index of the `sr` bit selecting action vs no-action. Must satisfy `ACT_BIT < DR_W`.
- `SYNC_STAGES`, default 2: synchroniser depth for `vs_udr`/`vs_uir`. Must be at least 2.
- `FIFO_DEPTH`, default 4: command queue depth. Must be a power of 2 and at least 2. Used only with `DEBUG_SLAVE_CMDQ_FIFO_EN`.

Ports:
- `clk` in 1: system clock; the block has one clock.
- `reset` in 1: reset is synchronous and active-high.
- `vs_udr` in 1: virtual update-DR level, asynchronous to `clk`.
- `vs_uir` in 1: virtual update-IR level, asynchronous to `clk`.
- `ir_in` in `IR_W`: current instruction. Stable while `vs_udr` is high.
- `sr` in `DR_W`: shifted data register. Stable while `vs_udr` is high.
- `cmd_ready` in 1: consumer accepts the head command.
- `cmd_valid` out 1: head command available.
- `cmd_ir` out `IR_W`: head command instruction.
- `jdo` out `DR_W`: head command data.
- `take_action` out `NUM_IR`: one-hot pulse on pop when `data[ACT_BIT]=1`; bit index = `cmd_ir`.
- `take_no_action` out `NUM_IR`: one-hot pulse on pop when `data[ACT_BIT]=0`.
- `ir_update` out 1: one-cycle pulse on a synchronised `vs_uir` rising edge.
- `overflow` out 1: sticky; a command was dropped.
- `level` out `$clog2(FIFO_DEPTH)+1`: number of queued commands.

## Operation
- Each strobe passes through a `SYNC_STAGES` flop chain, then a rising-edge detector.
- Arming rule: an edge is recognised only after the synchronised level has been observed 0 at least once since reset. A strobe that is already high at reset release produces no command.
- On a `udr` edge, `{ir_in, sr}` is captured and pushed.
- Push when not full: the command is stored and `level` increments.
- Push when full without a same-cycle pop: the command is dropped, `overflow` is set to 1, and queue contents are unchanged.
- Pop occurs when `cmd_valid && cmd_ready`. In the pop cycle, exactly one bit of `take_action` or `take_no_action` pulses (index `cmd_ir`, selected by `jdo[ACT_BIT]`). Pulses are registered and are high in the cycle after the pop.
- Push and pop in the same cycle:
  - Full queue: the push is accepted and `level` is unchanged.
  - Empty queue: the pop is not possible because `cmd_valid` is 0; the push proceeds.
- `ir_update` edge: pulses `ir_update` and clears `overflow`. If a new drop happens in the same cycle, `overflow` stays 1 (set wins).
- `cmd_valid`, `cmd_ir` and `jdo` are held stable while `cmd_valid && !cmd_ready`.
- `jdo` shows the head entry. When the queue is empty, `jdo` holds the last popped value.

## Timing
- Reset values: `cmd_valid=0`, `cmd_ir=0`, `jdo=0`, `take_action=0`, `take_no_action=0`, `ir_update=0`, `overflow=0`, `level=0`. Synchronisers and edge registers are 0 and disarmed.
- Reset asserted mid-operation: the queue is flushed on that edge and any in-flight strobe is discarded. The arming rule then applies again.
- Latency from `vs_udr` rising (sampled at edge N) to `cmd_valid=1`: `SYNC_STAGES+2` cycles (sync, edge detect/capture, queue output register).
- Latency from `vs_uir` rising to `ir_update`: `SYNC_STAGES+1` cycles.
- Throughput: one push and one pop per cycle.
- Pulse latency: one cycle after the pop handshake, width one cycle.

## Configuration
- `DEBUG_SLAVE_CMDQ_FIFO_EN` defined: a circular queue of `FIFO_DEPTH` entries (read/write pointers plus a wrap bit) stores commands. `level` ranges 0..`FIFO_DEPTH`.
- `DEBUG_SLAVE_CMDQ_FIFO_EN` undefined: a single holding register stores the command (effective depth 1) and `FIFO_DEPTH` is ignored. `level` is 0 or 1. A push while full without a same-cycle pop is dropped and sets `overflow`. All timing above is unchanged.

## Structure
- Package `debug_slave_pkg` holds:
  - a `dbg_cmd_t` struct `{ir, data}` parameterised through localparams `DBG_IR_W`/`DBG_DR_W`;
  - the default `ACT_BIT` constant;
  - a function `ir_onehot(ir)`.
- Sub-module `debug_slave_bit_sync`: a `SYNC_STAGES`-deep synchroniser with synchronous active-high reset. It is instantiated twice, once for `udr` and once for `uir`.
- The queue is inline, selected by the macro. There is no further sub-module.

## Test plan
- Reset release with `vs_udr=1` held: no `cmd_valid` for 20 cycles. Then drop and raise `vs_udr` with `ir_in=2'b01`, `sr[34]=1` → `cmd_valid` at +4 cycles, `cmd_ir=1`, and `take_action=4'b0010` one cycle after the `cmd_ready` pop.
- `sr=38'h2A_5A5A_5A5A`, `sr[34]=0`, `ir_in=3`, with `cmd_ready=1` → `jdo=38'h2A_5A5A_5A5A` and `take_no_action=4'b1000` for exactly one cycle.
- FIFO enabled, depth 4, `cmd_ready=0`, five `udr` strobes → `level=4`, `overflow=1`. Pops return the first four commands in order; the fifth is absent.
- Full queue with a strobe arriving in the same cycle as a pop → `level` stays 4, `overflow` stays 0, and the new command is popped last.
- `overflow=1`, then a `vs_uir` strobe → `ir_update` pulse at `SYNC_STAGES+1` and `overflow=0` the following cycle. `reset` asserted with 3 queued commands → `level=0` and `cmd_valid=0` next cycle.
- Macro undefined: two strobes with `cmd_ready=0` → `level=1`, `overflow=1`, and `jdo` holds the first command.
